riscv_div: RTL and testbench
============================

# riscv_div

Multi-cycle, parametrised integer divider for the RV32M/RV64M division group (DIV, DIVU, REM, REMU). It extends the team's combinational N-bit subtractor into a sequential restoring shift-subtract engine: one subtract step per cycle, a start/done handshake, signed and unsigned modes, and the RISC-V corner-case results. It sits beside the ALU in the execute stage. The pipeline stalls while `busy` is high.

## Interface
- `N`, default 32: operand and result width. Must be ≥ 2.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `start`  in  1: request. Sampled only while idle (`busy` = 0).
- `op`  in  2: operation. 00 DIV, 01 DIVU, 10 REM, 11 REMU. Sampled with `start`.
- `a`  in  N: dividend. Sampled with `start`.
- `b`  in  N: divisor. Sampled with `start`.
- `busy`  out  1: high in every non-IDLE state.
- `done`  out  1: one-cycle pulse. `result` is valid in that cycle.
- `result`  out  N: quotient for DIV/DIVU, remainder for REM/REMU. Holds its value until the next `done`.

## Operation
- States:
  - IDLE: `start` = 1 → latch `op`, `a`, `b`. Then:
    - divisor zero → DONE.
    - signed overflow (DIV/REM with a = −2^(N−1), b = −1) → DONE.
    - otherwise → CALC.
  - CALC: runs for exactly N cycles, then → DONE.
  - DONE: one cycle, then → IDLE. Never exits to CALC directly.
- Signed ops (DIV, REM): operands are converted to magnitudes at load. Unsigned ops use the raw operands.
- Datapath registers:
  - quotient/dividend shift register Q (N bits).
  - partial remainder R (N+1 bits).
  - divisor magnitude D (N bits).
  - step counter (clog2(N+1) bits).
- Each CALC step:
  - T = {R[N−1:0], Q[N−1]} − {1'b0, D}, computed at N+1 bits.
  - T[N] = 0 → R ← T, Q ← {Q[N−2:0], 1}.
  - T[N] = 1 → R ← {R[N−1:0], Q[N−1]}, Q ← {Q[N−2:0], 0}.
- Sign fix-up, applied on entry to DONE for signed ops:
  - quotient is negated if sign(a) ≠ sign(b).
  - remainder is negated if a < 0, so it takes the dividend's sign.
- Corner results, registered on entry to DONE:
  - b = 0: DIV/DIVU give all ones. REM/REMU give a.
  - signed overflow: DIV gives a (= −2^(N−1)). REM gives 0.
  - a = 0 with b ≠ 0: normal CALC path, result 0.
- Arithmetic is two's complement, modulo 2^N. The magnitude of −2^(N−1) is 2^(N−1), which is representable unsigned in N bits.
- `start` while `busy` = 1: ignored. No queuing, no effect on the current operation.
- `op`, `a`, `b` changes after the start cycle: no effect, because the operands are latched.

## Timing
- Start sampled at edge 0, normal path:
  - CALC occupies cycles 1..N.
  - DONE in cycle N+1: `done` = 1, `result` valid.
  - IDLE in cycle N+2. The earliest next `start` is sampled at the end of cycle N+2.
- Corner path: DONE in cycle 1. Latency is 1.
- `busy` rises in cycle 1 and falls in the cycle after DONE.
- `done` is high in exactly one cycle per accepted start.
- Reset (`rst_n` = 0 at a rising edge), any state including mid-CALC:
  - state → IDLE; `busy` = 0, `done` = 0, `result` = 0.
  - counter and all datapath registers → 0.
  - the aborted operation produces no `done`.
- `start` and `rst_n` = 0 in the same cycle: reset wins, and the request is dropped.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- N=32, DIVU a=100, b=7 at cycle 0 → `busy` in cycles 1–33, `done` only in cycle 33, `result` = 14. Repeat with REMU → `result` = 2.
- Signed, N=32:
  - DIV −7 / 2 → 0xFFFFFFFD (−3).
  - REM −7 / 2 → 0xFFFFFFFF (−1).
  - DIV 7 / −2 → 0xFFFFFFFD.
  - REM 7 / −2 → 1.
  - `done` in cycle 33 for each.
- Corner cases, each with `done` in cycle 1 and `busy` only in cycle 1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Handshake:
  - `start` with 1/1 at cycle 0, then `start` with 9/3 pulsed at cycle 5 → only one `done` (cycle 33, `result` = 1).
  - `start` with 9/3 in cycle 34 → `done` in cycle 67 with `result` = 3.
- Reset mid-operation: `rst_n` low at cycle 10 of a DIVU → cycle 11 shows `busy` = 0, `done` = 0, `result` = 0. No `done` appears later.
- Parameter sweep N=8: random signed/unsigned pairs, including 0x80 / 0xFF and divide by zero, against a reference model → exact match, `done` in cycle 9 (normal path) or cycle 1 (corner path).

Source files
------------

// File: rtl/riscv_div.sv
// Sequential restoring divider for DIV/DIVU/REM/REMU: one shift-subtract step per cycle,
// start/done handshake, RISC-V divide-by-zero and signed-overflow results.
module riscv_div #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [N-1:0] MIN_NEG = {1'b1, (N-1)'(0)};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  q;
    logic [N:0]    r;
    logic [N-1:0]  d;
    logic [CW-1:0] cnt;
    logic          is_rem;
    logic          neg_q;
    logic          neg_r;

    logic          is_signed_c;
    logic          ovf_c;
    logic [N-1:0]  a_mag_c;
    logic [N-1:0]  b_mag_c;
    logic [N:0]    shifted_c;
    logic [N:0]    trial_c;
    logic [N:0]    r_nx_c;
    logic [N-1:0]  q_nx_c;
    logic [N-1:0]  q_res_c;
    logic [N-1:0]  rem_res_c;

    // Operand conditioning at load: magnitudes for signed ops, overflow detection.
    always_comb begin
        is_signed_c = ~op[0];
        ovf_c       = is_signed_c && (a == MIN_NEG) && (b == '1);
        a_mag_c     = (is_signed_c && a[N-1]) ? -a : a;
        b_mag_c     = (is_signed_c && b[N-1]) ? -b : b;
    end

    // One restoring step plus the sign fix-up applied to the final step's values.
    always_comb begin
        shifted_c = (r << 1) | (N+1)'(q[N-1]);
        trial_c   = shifted_c - {1'b0, d};
        r_nx_c    = shifted_c;
        q_nx_c    = {q[N-2:0], 1'b0};
        if (!trial_c[N]) begin
            r_nx_c = trial_c;
            q_nx_c = {q[N-2:0], 1'b1};
        end
        q_res_c   = neg_q ? -q_nx_c : q_nx_c;
        rem_res_c = neg_r ? -r_nx_c[N-1:0] : r_nx_c[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            q      <= '0;
            r      <= '0;
            d      <= '0;
            cnt    <= '0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        is_rem <= op[1];
                        neg_q  <= is_signed_c && (a[N-1] ^ b[N-1]);
                        neg_r  <= is_signed_c && a[N-1];
                        q      <= a_mag_c;
                        r      <= '0;
                        d      <= b_mag_c;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        if (b == '0) begin
                            result <= op[1] ? a : '1;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else if (ovf_c) begin
                            result <= op[1] ? '0 : a;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    q   <= q_nx_c;
                    r   <= r_nx_c;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        result <= is_rem ? rem_res_c : q_res_c;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_div.sv
// Scoreboard bench for riscv_div at N=32 and N=8: stimulus pushes expected result and
// completion cycle, a monitor pops and checks on every done pulse.
module tb_riscv_div;

    typedef struct {
        int unsigned cnt;
        logic [31:0] res;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start32 = 1'b0;
    logic [1:0]  op32 = 2'b00;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        busy32;
    logic        done32;
    logic [31:0] result32;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic        done8;
    logic [7:0]  result8;

    exp_t        q32[$];
    exp_t        q8[$];
    int unsigned ecnt = 0;
    bit          rst_q = 1'b0;
    int          total = 0;
    int          bad = 0;

    riscv_div #(.N(32)) u_div32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(result32)
    );

    riscv_div #(.N(8)) u_div8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8)
    );

    always #5 clk = ~clk;

    // ecnt after edge k equals the cycle index k+1 used for done timing
    always @(posedge clk) begin
        ecnt  <= ecnt + 1;
        rst_q <= !rst_n;
    end

    always @(negedge clk) begin
        exp_t e;
        static bit prev_done32 = 1'b0;
        static bit prev_done8  = 1'b0;
        if (rst_q) begin
            total++;
            if (busy32 !== 1'b0 || done32 !== 1'b0 || result32 !== 32'h0 ||
                busy8 !== 1'b0 || done8 !== 1'b0 || result8 !== 8'h0) begin
                bad++;
                $display("FAIL reset_state: busy32=%b done32=%b result32=%h busy8=%b done8=%b result8=%h required all zero",
                         busy32, done32, result32, busy8, done8, result8);
            end
        end else begin
            if (prev_done32) begin
                total++;
                if (busy32 !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_after_done32: busy=%b required 0 at cycle %0d", busy32, ecnt);
                end
            end
            if (prev_done8) begin
                total++;
                if (busy8 !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_after_done8: busy=%b required 0 at cycle %0d", busy8, ecnt);
                end
            end
            if (done32 === 1'b1) begin
                total++;
                if (q32.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done32: cycle=%0d result=%h required no done", ecnt, result32);
                end else begin
                    e = q32.pop_front();
                    if (result32 !== e.res || ecnt != e.cnt || busy32 !== 1'b1) begin
                        bad++;
                        $display("FAIL %s: result=%h cycle=%0d busy=%b required result=%h cycle=%0d busy=1",
                                 e.name, result32, ecnt, busy32, e.res, e.cnt);
                    end
                end
            end
            if (done8 === 1'b1) begin
                total++;
                if (q8.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done8: cycle=%0d result=%h required no done", ecnt, result8);
                end else begin
                    e = q8.pop_front();
                    if ({24'h0, result8} !== e.res || ecnt != e.cnt || busy8 !== 1'b1) begin
                        bad++;
                        $display("FAIL %s: result=%h cycle=%0d busy=%b required result=%h cycle=%0d busy=1",
                                 e.name, result8, ecnt, busy8, e.res[7:0], e.cnt);
                    end
                end
            end
            if (q32.size() != 0 && ecnt > q32[0].cnt) begin
                e = q32.pop_front();
                total++;
                bad++;
                $display("FAIL %s: no done by cycle %0d required done at cycle %0d", e.name, ecnt, e.cnt);
            end
            if (q8.size() != 0 && ecnt > q8[0].cnt) begin
                e = q8.pop_front();
                total++;
                bad++;
                $display("FAIL %s: no done by cycle %0d required done at cycle %0d", e.name, ecnt, e.cnt);
            end
        end
        prev_done32 = (done32 === 1'b1);
        prev_done8  = (done8 === 1'b1);
    end

    function automatic logic [7:0] ref8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        int sx = $signed(x);
        int sy = $signed(y);
        if (y == 8'h00) return o[1] ? x : 8'hFF;
        if (!o[0]) begin
            if (x == 8'h80 && y == 8'hFF) return o[1] ? 8'h00 : 8'h80;
            return o[1] ? 8'(sx % sy) : 8'(sx / sy);
        end
        return o[1] ? x % y : x / y;
    endfunction

    task automatic issue32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp_res, input bit corner, input bit push, input string nm);
        @(negedge clk);
        start32 = 1'b1; op32 = o; a32 = x; b32 = y;
        @(posedge clk);
        #1;
        start32 = 1'b0; op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
        if (push) q32.push_back('{ecnt + (corner ? 0 : 32), exp_res, nm});
    endtask

    task automatic issue8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] exp_res, input string nm);
        bit corner = (y == 8'h00) || (!o[0] && x == 8'h80 && y == 8'hFF);
        @(negedge clk);
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(posedge clk);
        #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        q8.push_back('{ecnt + (corner ? 0 : 8), {24'h0, exp_res}, nm});
    endtask

    task automatic wait32;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!busy32 && q32.size() == 0) break;
        end
    endtask

    task automatic wait8;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy8 && q8.size() == 0) break;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        issue32(2'b01, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1, "divu_100_7");             wait32;
        issue32(2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 1'b1, "remu_100_7");              wait32;
        issue32(2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 1'b1, "div_m7_2");    wait32;
        issue32(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b1, "rem_m7_2");    wait32;
        issue32(2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b1, "div_7_m2");    wait32;
        issue32(2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 1'b0, 1'b1, "rem_7_m2");           wait32;
        issue32(2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b1, "divu_by_zero");       wait32;
        issue32(2'b11, 32'd5, 32'd0, 32'd5, 1'b1, 1'b1, "remu_by_zero");              wait32;
        issue32(2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1, "div_ovf"); wait32;
        issue32(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b1, "rem_ovf");     wait32;
        issue32(2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, "divu_big");    wait32;
        issue32(2'b00, 32'd0, 32'd5, 32'd0, 1'b0, 1'b1, "div_zero_dividend");         wait32;

        // a start pulsed while busy must be dropped
        issue32(2'b01, 32'd1, 32'd1, 32'd1, 1'b0, 1'b1, "hs_first");
        repeat (3) @(negedge clk);
        start32 = 1'b1; op32 = 2'b01; a32 = 32'd9; b32 = 32'd3;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        wait32;
        issue32(2'b01, 32'd9, 32'd3, 32'd3, 1'b0, 1'b1, "hs_second");                 wait32;

        // reset mid-operation: no done may follow
        issue32(2'b01, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0, "");
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        issue8(2'b00, 8'h80, 8'hFF, 8'h80, "n8_div_ovf");      wait8;
        issue8(2'b10, 8'h80, 8'hFF, 8'h00, "n8_rem_ovf");      wait8;
        issue8(2'b01, 8'h80, 8'hFF, 8'h00, "n8_divu_80_ff");   wait8;
        issue8(2'b11, 8'h80, 8'hFF, 8'h80, "n8_remu_80_ff");   wait8;
        issue8(2'b00, 8'h05, 8'h00, 8'hFF, "n8_div_by_zero");  wait8;
        issue8(2'b11, 8'h37, 8'h00, 8'h37, "n8_remu_by_zero"); wait8;
        issue8(2'b00, 8'h9C, 8'h07, 8'hF2, "n8_div_m100_7");   wait8;
        issue8(2'b10, 8'h9C, 8'h07, 8'hFE, "n8_rem_m100_7");   wait8;
        issue8(2'b01, 8'hFF, 8'h10, 8'h0F, "n8_divu_ff_10");   wait8;
        issue8(2'b11, 8'hFF, 8'h10, 8'h0F, "n8_remu_ff_10");   wait8;
        issue8(2'b00, 8'h80, 8'h02, 8'hC0, "n8_div_min_2");    wait8;
        issue8(2'b10, 8'h7F, 8'h81, 8'h00, "n8_rem_7f_81");    wait8;
        issue8(2'b00, 8'h7F, 8'h81, 8'hFF, "n8_div_7f_81");    wait8;
        for (int i = 0; i < 16; i++) begin
            logic [1:0] o = 2'($urandom_range(0, 3));
            logic [7:0] x = 8'($urandom);
            logic [7:0] y = (i % 5 == 0) ? 8'h00 : 8'($urandom);
            issue8(o, x, y, ref8(o, x, y), "n8_rand");
            wait8;
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
